// File: rtl/req_tagger.sv
// req_tagger: stamps AXI AR requests with sequential tIDs and returns ARIDs in tID order at retirement
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

module req_tagger #(
    parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH        = `AXI_ID_WIDTH,
    parameter int TID_WIDTH       = `TID_WIDTH,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [TID_WIDTH-1:0]  req_tid_o,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    input  logic                  retire_i,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic                  rid_valid_o,
    output logic                  err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    logic                  req_valid_q, req_valid_d;
    logic [TID_WIDTH-1:0]  req_tid_q, req_tid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [TID_WIDTH-1:0]  tid_next_q, tid_next_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  err_q, err_d;
    logic [ID_WIDTH-1:0]   fifo_q [MAX_OUTSTANDING];
    logic                  busy;
    logic                  accept;
    logic                  pop;

    assign busy        = cnt_q != '0;
    assign arready_o   = (!req_valid_q | req_ready_i) & (cnt_q < MAX_CNT);
    assign accept      = arvalid_i & arready_o;
    assign pop         = retire_i & busy;
    assign req_valid_o = req_valid_q;
    assign req_tid_o   = req_tid_q;
    assign req_addr_o  = req_addr_q;
    assign rid_o       = busy ? fifo_q[rd_ptr_q] : '0;
    assign rid_valid_o = busy;
    assign err_o       = err_q;

    // Next state: load output slot on accept, drain it on handshake, track credits and FIFO pointers
    always_comb begin
        req_valid_d = accept | (req_valid_q & !req_ready_i);
        req_tid_d   = accept ? tid_next_q : req_tid_q;
        req_addr_d  = accept ? araddr_i : req_addr_q;
        tid_next_d  = accept ? tid_next_q + 1'b1 : tid_next_q;
        cnt_d       = cnt_q + CW'(accept) - CW'(pop);
        wr_ptr_d    = accept ? ((wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d    = pop ? ((rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        err_d       = err_q | (retire_i & !busy);
    end

    // State registers; a retire with nothing outstanding only raises the sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_valid_q <= 1'b0;
            req_tid_q   <= '0;
            req_addr_q  <= '0;
            tid_next_q  <= TID_WIDTH'(1);
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_tid_q   <= req_tid_d;
            req_addr_q  <= req_addr_d;
            tid_next_q  <= tid_next_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
        end
    end

    // ARID storage; contents past the pointers are never observed, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) fifo_q[wr_ptr_q] <= arid_i;
    end
endmodule

// File: tb/tb_req_tagger.sv
// tb_req_tagger: table vectors, directed corner sequences and random traffic against a queue-based model
module tb_req_tagger;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, arvalid, req_ready, retire;
    logic [3:0]  arid;
    logic [15:0] araddr;
    logic        arready_a, req_valid_a, rid_valid_a, err_a;
    logic [3:0]  req_tid_a, rid_a;
    logic [15:0] req_addr_a;
    logic        arready_b, req_valid_b, rid_valid_b, err_b;
    logic [2:0]  req_tid_b;
    logic [3:0]  rid_b;
    logic [15:0] req_addr_b;

    req_tagger #(.ADDR_WIDTH(16), .ID_WIDTH(4), .TID_WIDTH(4), .MAX_OUTSTANDING(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .arvalid_i(arvalid), .arready_o(arready_a), .arid_i(arid),
        .araddr_i(araddr), .req_valid_o(req_valid_a), .req_ready_i(req_ready), .req_tid_o(req_tid_a),
        .req_addr_o(req_addr_a), .retire_i(retire), .rid_o(rid_a), .rid_valid_o(rid_valid_a), .err_o(err_a));

    req_tagger #(.ADDR_WIDTH(16), .ID_WIDTH(4), .TID_WIDTH(3), .MAX_OUTSTANDING(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .arvalid_i(arvalid), .arready_o(arready_b), .arid_i(arid),
        .araddr_i(araddr), .req_valid_o(req_valid_b), .req_ready_i(req_ready), .req_tid_o(req_tid_b),
        .req_addr_o(req_addr_b), .retire_i(retire), .rid_o(rid_b), .rid_valid_o(rid_valid_b), .err_o(err_b));

    int passed = 0;
    int total  = 0;

    // Reference model: ARIDs in flight are a plain queue per instance; tIDs count modulo 2**TID_WIDTH
    int mx[2] = '{8, 7};
    int md[2] = '{16, 8};
    int m_tn[2], m_v[2], m_tid[2], m_addr[2], m_err[2];
    int q0[$], q1[$];

    function automatic int qsz(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int head(int k);
        if (qsz(k) == 0) return 0;
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic int m_ar(int k);
        return ((m_v[k] == 0 || req_ready) && qsz(k) < mx[k]) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tn[k] = 1; m_v[k] = 0; m_tid[k] = 0; m_addr[k] = 0; m_err[k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_edge();
        int acc[2];
        int pp[2];
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            acc[k] = (arvalid && m_ar(k) == 1) ? 1 : 0;
            pp[k]  = (retire && qsz(k) > 0) ? 1 : 0;
            if (retire && qsz(k) == 0) m_err[k] = 1;
        end
        if (pp[0] == 1) void'(q0.pop_front());
        if (pp[1] == 1) void'(q1.pop_front());
        if (acc[0] == 1) q0.push_back(int'(arid));
        if (acc[1] == 1) q1.push_back(int'(arid));
        for (int k = 0; k < 2; k++) begin
            if (acc[k] == 1) begin
                m_v[k] = 1; m_tid[k] = m_tn[k]; m_addr[k] = int'(araddr);
                m_tn[k] = (m_tn[k] + 1) % md[k];
            end else if (req_ready) m_v[k] = 0;
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_inst(string s, int k, int v, int tid, int addr, int rid, int rv, int err);
        chk({s, ".req_valid"}, v, m_v[k]);
        chk({s, ".req_tid"}, tid, m_tid[k]);
        chk({s, ".req_addr"}, addr, m_addr[k]);
        chk({s, ".rid"}, rid, head(k));
        chk({s, ".rid_valid"}, rv, (qsz(k) != 0) ? 1 : 0);
        chk({s, ".err"}, err, m_err[k]);
    endtask

    task automatic step();
        #1;
        chk("a.arready", int'(arready_a), m_ar(0));
        chk("b.arready", int'(arready_b), m_ar(1));
        @(posedge clk);
        model_edge();
        #2;
        chk_inst("a", 0, int'(req_valid_a), int'(req_tid_a), int'(req_addr_a), int'(rid_a),
                 int'(rid_valid_a), int'(err_a));
        chk_inst("b", 1, int'(req_valid_b), int'(req_tid_b), int'(req_addr_b), int'(rid_b),
                 int'(rid_valid_b), int'(err_b));
    endtask

    task automatic drive(bit v, bit [3:0] id, bit [15:0] a, bit rdy, bit ret);
        arvalid = v; arid = id; araddr = a; req_ready = rdy; retire = ret;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit        arv;
        bit [3:0]  id;
        bit [15:0] addr;
        bit        rdy;
        bit        ret;
        bit        e_ar;
        bit        e_v;
        bit [3:0]  e_tid;
        bit [15:0] e_addr;
        bit [3:0]  e_rid;
        bit        e_rv;
        bit        e_err;
    } vec_t;

    vec_t tbl[13];
    int   wexp[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        //             arv id  addr      rdy ret | ar v tid addr      rid rv err
        tbl[0]  = '{1, 5, 16'h100, 1, 0, 1, 1, 1, 16'h100, 5, 1, 0};
        tbl[1]  = '{1, 6, 16'h140, 1, 0, 1, 1, 2, 16'h140, 5, 1, 0};
        tbl[2]  = '{1, 7, 16'h180, 1, 0, 1, 1, 3, 16'h180, 5, 1, 0};
        tbl[3]  = '{1, 8, 16'h1C0, 0, 0, 0, 1, 3, 16'h180, 5, 1, 0};
        tbl[4]  = '{1, 8, 16'h1C0, 0, 0, 0, 1, 3, 16'h180, 5, 1, 0};
        tbl[5]  = '{1, 8, 16'h1C0, 1, 0, 1, 1, 4, 16'h1C0, 5, 1, 0};
        tbl[6]  = '{0, 0, 16'h000, 1, 1, 1, 0, 4, 16'h1C0, 6, 1, 0};
        tbl[7]  = '{1, 9, 16'h200, 1, 1, 1, 1, 5, 16'h200, 7, 1, 0};
        tbl[8]  = '{0, 0, 16'h000, 1, 1, 1, 0, 5, 16'h200, 8, 1, 0};
        tbl[9]  = '{0, 0, 16'h000, 1, 1, 1, 0, 5, 16'h200, 9, 1, 0};
        tbl[10] = '{0, 0, 16'h000, 1, 1, 1, 0, 5, 16'h200, 0, 0, 0};
        tbl[11] = '{0, 0, 16'h000, 1, 1, 1, 0, 5, 16'h200, 0, 0, 1};
        tbl[12] = '{0, 0, 16'h000, 1, 0, 1, 0, 5, 16'h200, 0, 0, 1};

        model_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk("reset req_valid", int'(req_valid_a), 0);
        chk("reset rid_valid", int'(rid_valid_a), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].arv, tbl[i].id, tbl[i].addr, tbl[i].rdy, tbl[i].ret);
            #1;
            chk($sformatf("tbl%0d arready", i), int'(arready_a), int'(tbl[i].e_ar));
            step();
            chk($sformatf("tbl%0d req_valid", i), int'(req_valid_a), int'(tbl[i].e_v));
            chk($sformatf("tbl%0d req_tid", i), int'(req_tid_a), int'(tbl[i].e_tid));
            chk($sformatf("tbl%0d req_addr", i), int'(req_addr_a), int'(tbl[i].e_addr));
            chk($sformatf("tbl%0d rid", i), int'(rid_a), int'(tbl[i].e_rid));
            chk($sformatf("tbl%0d rid_valid", i), int'(rid_valid_a), int'(tbl[i].e_rv));
            chk($sformatf("tbl%0d err", i), int'(err_a), int'(tbl[i].e_err));
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'(i), 16'(i * 16), 1, 0);
            step();
        end
        drive(0, 0, 0, 1, 0);
        #1;
        chk("credit full arready", int'(arready_a), 0);
        step();
        drive(0, 0, 0, 1, 1);
        #1;
        chk("credit retire-cycle arready", int'(arready_a), 0);
        step();
        drive(0, 0, 0, 1, 0);
        #1;
        chk("credit reopen arready", int'(arready_a), 1);
        chk("credit rid advance", int'(rid_a), 1);
        step();

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1, 4'(i + 3), 16'(i), 1, i > 0);
            step();
            chk($sformatf("wrap tid%0d", i), int'(req_tid_b), wexp[i]);
            chk($sformatf("wrap rid%0d", i), int'(rid_b), i + 3);
        end
        drive(0, 0, 0, 1, 1);
        step();
        chk("drain err", int'(err_b), 0);
        step();
        chk("empty retire err", int'(err_b), 1);
        chk("empty retire rid_valid", int'(rid_valid_b), 0);
        drive(0, 0, 0, 1, 0);
        step();
        chk("err sticky", int'(err_b), 1);

        for (int i = 0; i < 4; i++) begin
            drive(1, 4'(i + 10), 16'(16'h300 + i), 1, 0);
            step();
        end
        do_reset();
        chk("midrst req_valid", int'(req_valid_a), 0);
        chk("midrst req_tid", int'(req_tid_a), 0);
        chk("midrst req_addr", int'(req_addr_a), 0);
        chk("midrst rid", int'(rid_a), 0);
        chk("midrst rid_valid", int'(rid_valid_a), 0);
        chk("midrst err", int'(err_a), 0);
        drive(1, 3, 16'h55, 1, 0);
        #1;
        chk("midrst arready", int'(arready_a), 1);
        step();
        chk("midrst first tid", int'(req_tid_a), 1);

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
